// File: rtl/tt6581_pkg.sv
// Shared definitions for the envelope generator: sizes, phase/FSM encodings
// and the rate-period table (samples per level step).
package tt6581_pkg;

    localparam int NUM_VOICES = 3;
    localparam int ENV_W      = 8;
    localparam int CNT_W      = 13;
    localparam int PERIOD_W   = 11;
    localparam int VOICE_W    = 2;

    typedef enum logic [1:0] {
        ENV_ATTACK,
        ENV_DECAY,
        ENV_RELEASE
    } env_phase_e;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_LOOKUP,
        ENV_UPDATE,
        ENV_DONE
    } env_state_e;

    // Samples per level step at 50 kHz; index 0 is the fastest rate.
    localparam logic [PERIOD_W-1:0] RATE_PERIOD_LUT [16] = '{
        11'd1,   11'd2,   11'd3,   11'd5,
        11'd7,   11'd11,  11'd13,  11'd16,
        11'd20,  11'd49,  11'd98,  11'd157,
        11'd196, 11'd588, 11'd980, 11'd1569
    };

endpackage

// File: rtl/env_generator_if.sv
// Envelope handshake between the master controller and the envelope generator.
interface env_generator_if;
    import tt6581_pkg::*;

    logic             env_start_i;
    logic [1:0]       env_voice_i;
    logic             env_gate_i;
    logic [3:0]       env_attack_i;
    logic [3:0]       env_decay_i;
    logic [3:0]       env_sustain_i;
    logic [3:0]       env_release_i;
    logic             env_ready_o;
    logic [ENV_W-1:0] env_o;
    logic             env_busy_o;

    // Controller side
    modport master (
        output env_start_i, env_voice_i, env_gate_i,
        output env_attack_i, env_decay_i, env_sustain_i, env_release_i,
        input  env_ready_o, env_o, env_busy_o
    );

    // Envelope generator side
    modport slave (
        input  env_start_i, env_voice_i, env_gate_i,
        input  env_attack_i, env_decay_i, env_sustain_i, env_release_i,
        output env_ready_o, env_o, env_busy_o
    );

endinterface

// File: rtl/env_rate_lut.sv
// Combinational rate ROM: 4-bit rate index -> samples per envelope step.
module env_rate_lut
    import tt6581_pkg::*;
(
    input  logic [3:0]          i_idx,
    output logic [PERIOD_W-1:0] o_period
);

    assign o_period = RATE_PERIOD_LUT[i_idx];

endmodule

// File: rtl/env_generator.sv
// Multi-voice ADSR envelope generator. Each start advances one voice by a
// single step and returns its new level with a one-cycle ready pulse,
// exactly three cycles after the start is accepted.
module env_generator
    import tt6581_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    env_generator_if.slave env_bus
);

    // FSM
    env_state_e r_state;
    env_state_e w_state_next;
    logic       w_busy;
    logic       w_ready_set;

    // Request latched when a start is accepted
    logic [VOICE_W-1:0] r_voice;
    logic               r_valid;
    logic               r_gate;
    logic [3:0]         r_attack;
    logic [3:0]         r_decay;
    logic [3:0]         r_sustain;
    logic [3:0]         r_release;

    // Per-voice stored state
    logic [ENV_W-1:0] r_level     [NUM_VOICES];
    env_phase_e       r_phase     [NUM_VOICES];
    logic [CNT_W-1:0] r_cnt       [NUM_VOICES];
    logic             r_gate_prev [NUM_VOICES];

    // Working copy captured in LOOKUP, consumed in UPDATE
    logic [ENV_W-1:0] r_level_cur;
    env_phase_e       r_phase_cur;
    logic [CNT_W-1:0] r_cnt_cur;
    logic [CNT_W-1:0] r_period;

    // Outputs
    logic [ENV_W-1:0] r_env;
    logic             r_ready;

    // LOOKUP-stage combinational signals
    logic [VOICE_W-1:0]  w_vidx;
    logic                w_rise;
    logic                w_fall;
    env_phase_e          w_phase_eff;
    logic [CNT_W-1:0]    w_cnt_eff;
    logic [3:0]          w_rate_idx;
    logic [PERIOD_W-1:0] w_lut_period;
    logic [CNT_W-1:0]    w_period_base;
    logic [CNT_W-1:0]    w_period;

    // UPDATE-stage combinational signals
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_new;
    logic [ENV_W-1:0] w_level_new;
    env_phase_e       w_phase_new;

    env_rate_lut u_rate_lut (
        .i_idx    (w_rate_idx),
        .o_period (w_lut_period)
    );

    // State register
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the always blocks evaluate in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ENV_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state: fixed four-step walk; starts outside IDLE are ignored
    // NOTE: the default assignment at the top keeps this block free of inferred
    // latches even when no case branch assigns the signal.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ENV_IDLE:   if (env_bus.env_start_i) w_state_next = ENV_LOOKUP;
            ENV_LOOKUP: w_state_next = ENV_UPDATE;
            ENV_UPDATE: w_state_next = ENV_DONE;
            ENV_DONE:   w_state_next = ENV_IDLE;
            default:    w_state_next = ENV_IDLE;
        endcase
    end

    // FSM outputs: busy outside IDLE, ready request while in DONE
    always_comb begin
        w_busy      = (r_state != ENV_IDLE);
        w_ready_set = (r_state == ENV_DONE);
    end

    // Capture the request on an accepted start
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_voice   <= '0;
            r_valid   <= 1'b0;
            r_gate    <= 1'b0;
            r_attack  <= '0;
            r_decay   <= '0;
            r_sustain <= '0;
            r_release <= '0;
        end else if (r_state == ENV_IDLE && env_bus.env_start_i) begin
            r_voice   <= env_bus.env_voice_i;
            r_valid   <= {1'b0, env_bus.env_voice_i} < (VOICE_W + 1)'(NUM_VOICES);
            r_gate    <= env_bus.env_gate_i;
            r_attack  <= env_bus.env_attack_i;
            r_decay   <= env_bus.env_decay_i;
            r_sustain <= env_bus.env_sustain_i;
            r_release <= env_bus.env_release_i;
        end
    end

    // Gate-edge handling and period selection for the addressed voice
    always_comb begin
        // Out-of-range voices are clamped to a legal index; their result is discarded
        w_vidx      = r_valid ? r_voice : '0;
        w_rise      = r_gate & ~r_gate_prev[w_vidx];
        w_fall      = ~r_gate & r_gate_prev[w_vidx];
        w_phase_eff = r_phase[w_vidx];
        w_cnt_eff   = r_cnt[w_vidx];
        if (w_rise) begin
            w_phase_eff = ENV_ATTACK;
            w_cnt_eff   = '0;
        end else if (w_fall) begin
            w_phase_eff = ENV_RELEASE;
            w_cnt_eff   = '0;
        end
        unique case (w_phase_eff)
            ENV_ATTACK: w_rate_idx = r_attack;
            ENV_DECAY:  w_rate_idx = r_decay;
            default:    w_rate_idx = r_release;
        endcase
        w_period_base = CNT_W'(w_lut_period);
        // Decay and release run three times slower than attack
        w_period = (w_phase_eff == ENV_ATTACK) ? w_period_base
                                               : (w_period_base << 1) + w_period_base;
    end

    // Working copy of the addressed voice, taken in LOOKUP
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_level_cur <= '0;
            r_phase_cur <= ENV_RELEASE;
            r_cnt_cur   <= '0;
            r_period    <= '0;
        end else if (r_state == ENV_LOOKUP) begin
            r_level_cur <= r_level[w_vidx];
            r_phase_cur <= w_phase_eff;
            r_cnt_cur   <= w_cnt_eff;
            r_period    <= w_period;
        end
    end

    // One ADSR step: advance the rate counter, move the level on wrap
    always_comb begin
        w_cnt_inc   = r_cnt_cur + CNT_W'(1);
        w_cnt_new   = w_cnt_inc;
        w_level_new = r_level_cur;
        w_phase_new = r_phase_cur;
        if (w_cnt_inc >= r_period) begin
            w_cnt_new = '0;
            unique case (r_phase_cur)
                ENV_ATTACK: begin
                    if (r_level_cur != '1) w_level_new = r_level_cur + ENV_W'(1);
                    if (w_level_new == '1) w_phase_new = ENV_DECAY;
                end
                ENV_DECAY: begin
                    // Sustain nibble replicated gives S*17, spanning 0..255
                    if (r_level_cur > {r_sustain, r_sustain}) w_level_new = r_level_cur - ENV_W'(1);
                end
                default: begin
                    if (r_level_cur != '0) w_level_new = r_level_cur - ENV_W'(1);
                end
            endcase
        end
    end

    // Write the stepped state back to the addressed voice
    // NOTE: the per-voice arrays are reset explicitly because every voice must
    // start silent in RELEASE; a plain RAM without reset would not guarantee that.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_level[i]     <= '0;
                r_phase[i]     <= ENV_RELEASE;
                r_cnt[i]       <= '0;
                r_gate_prev[i] <= 1'b0;
            end
        end else if (r_state == ENV_UPDATE && r_valid) begin
            r_level[w_vidx]     <= w_level_new;
            r_phase[w_vidx]     <= w_phase_new;
            r_cnt[w_vidx]       <= w_cnt_new;
            r_gate_prev[w_vidx] <= r_gate;
        end
    end

    // Output level register and ready pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_env   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= w_ready_set;
            if (r_state == ENV_UPDATE) r_env <= r_valid ? w_level_new : '0;
        end
    end

    assign env_bus.env_ready_o = r_ready;
    assign env_bus.env_o       = r_env;
    assign env_bus.env_busy_o  = w_busy;

endmodule
